// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for the single memory port: the CPU always wins, DMA bursts fill idle cycles.
// Define MEM_ARB_STATS_EN to add the saturating conflict_cnt output.
module mem_arbiter #(
    parameter int ADDR_STEP = 2,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_memread,
    input  logic [1:0]  cpu_memwrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_write,
    input  logic [31:0] dma_addr,
    input  logic [3:0]  dma_len,
    input  logic [31:0] dma_wdata,
    output logic        dma_wnext,
    output logic [31:0] dma_rdata,
    output logic        dma_valid,
    output logic        dma_done,
    output logic        dma_busy,
    output logic        mem_read,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] conflict_cnt
`endif
);

    localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_next;
    logic [31:0]     addr_q, addr_next;
    logic [3:0]      rem_q, rem_next;
    logic            write_q, write_next;
    logic [CW-1:0]   cnt_q, cnt_next;
    logic [31:0]     rdata_q, rdata_next;
    logic            valid_q, valid_next;
    logic            word_done;
    logic            dma_rd;
    logic            dma_wr;
    logic            cpu_act;

    assign cpu_act = cpu_memread | (cpu_memwrite != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            addr_q  <= addr_next;
            rem_q   <= rem_next;
            write_q <= write_next;
            cnt_q   <= cnt_next;
            rdata_q <= rdata_next;
            valid_q <= valid_next;
        end
    end

    // Any CPU activity stalls ISSUE and aborts WAIT so the word is retried from its address phase.
    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        rem_next   = rem_q;
        write_next = write_q;
        cnt_next   = cnt_q;
        rdata_next = rdata_q;
        valid_next = 1'b0;
        word_done  = 1'b0;
        dma_rd     = 1'b0;
        dma_wr     = 1'b0;
        dma_wnext  = 1'b0;
        case (state)
            IDLE: begin
                if (dma_req) begin
                    addr_next  = dma_addr;
                    rem_next   = dma_len;
                    write_next = dma_write;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!cpu_act) begin
                    if (write_q) begin
                        dma_wr    = 1'b1;
                        dma_wnext = 1'b1;
                        word_done = 1'b1;
                    end else begin
                        dma_rd     = 1'b1;
                        cnt_next   = CW'(RD_LAT);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cpu_act) begin
                    state_next = ISSUE;
                end else begin
                    dma_rd   = 1'b1;
                    cnt_next = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        rdata_next = mem_rdata;
                        valid_next = 1'b1;
                        word_done  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                rdata_next = '0;
            end
            default: state_next = IDLE;
        endcase
        if (word_done) begin
            if (rem_q != 4'd0) begin
                addr_next  = addr_q + 32'(ADDR_STEP);
                rem_next   = rem_q - 4'd1;
                state_next = ISSUE;
            end else begin
                state_next = DONE;
            end
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 2'd0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_act) begin
            mem_read  = cpu_memread;
            mem_write = cpu_memwrite;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_rd) begin
            mem_read = 1'b1;
            mem_addr = addr_q;
        end else if (dma_wr) begin
            mem_write = 2'd2;
            mem_addr  = addr_q;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = rdata_q;
    assign dma_valid = valid_q;
    assign dma_done  = (state == DONE);
    assign dma_busy  = (state != IDLE);

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if ((state == ISSUE || state == WAIT) && cpu_act && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed bursts push expected events, a negedge monitor checks them.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_memread;
    logic [1:0]  cpu_memwrite;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        dma_req;
    logic        dma_write;
    logic [31:0] dma_addr;
    logic [3:0]  dma_len;
    logic [31:0] dma_wdata;
    logic        dma_wnext;
    logic [31:0] dma_rdata;
    logic        dma_valid;
    logic        dma_done;
    logic        dma_busy;
    logic        mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        wr_q[$];
    exp_t        rd_q[$];
    int          done_q[$];
    int          tests_run;
    int          tests_failed;
    int          cyc;
    int          widx;
    int          wcount;
    int          t0;
    logic        use_fixed;
    logic [31:0] fixed_rdata;

    mem_arbiter #(.ADDR_STEP(2), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr),
        .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_wnext(dma_wnext),
        .dma_rdata(dma_rdata), .dma_valid(dma_valid), .dma_done(dma_done),
        .dma_busy(dma_busy), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial widx = 0;
    always @(posedge clk) if (dma_wnext) widx <= widx + 1;
    assign dma_wdata = 32'hD000_0000 + 32'(widx);

    // Memory answers with an address-derived word unless a fixed value is forced.
    always_comb mem_rdata = use_fixed ? fixed_rdata : (mem_addr ^ 32'h5A5A_0000);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic noteUnexpected(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
    endtask

    task automatic applyStimulus(input logic rd, input logic [1:0] wr, input logic [31:0] a, input logic req);
        @(posedge clk);
        #1;
        cpu_memread  = rd;
        cpu_memwrite = wr;
        cpu_addr     = a;
        dma_req      = req;
        #1;
    endtask

    task automatic pushWrite(input int c, input logic [31:0] a);
        exp_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = 32'hD000_0000 + 32'(wcount);
        wcount++;
        wr_q.push_back(e);
    endtask

    task automatic pushRead(input int c, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.addr = '0;
        e.data = d;
        rd_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dma_wnext) begin
                if (wr_q.size() == 0) begin
                    noteUnexpected("wr_unexpected");
                end else begin
                    e = wr_q.pop_front();
                    checkOutput("wr_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("wr_addr", mem_addr, e.addr);
                    checkOutput("wr_data", mem_wdata, e.data);
                    checkOutput("wr_code", 32'(mem_write), 32'd2);
                end
            end else if (mem_write == 2'd2) begin
                noteUnexpected("dma_write_without_wnext");
            end
            if (dma_valid) begin
                if (rd_q.size() == 0) begin
                    noteUnexpected("rd_unexpected");
                end else begin
                    e = rd_q.pop_front();
                    checkOutput("rd_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("rd_data", dma_rdata, e.data);
                end
            end
            if (dma_done) begin
                if (done_q.size() == 0) begin
                    noteUnexpected("done_unexpected");
                end else begin
                    checkOutput("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        wcount       = 0;
        rst          = 1'b1;
        cpu_memread  = 1'b0;
        cpu_memwrite = 2'd0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        dma_req      = 1'b0;
        dma_write    = 1'b0;
        dma_addr     = '0;
        dma_len      = '0;
        use_fixed    = 1'b0;
        fixed_rdata  = '0;

        applyStimulus(0, 2'd0, 32'h0, 0);
        applyStimulus(0, 2'd0, 32'h0, 0);
        rst = 1'b0;
        applyStimulus(0, 2'd0, 32'h0, 0);
        checkOutput("reset_dma_flags", {28'd0, dma_busy, dma_valid, dma_done, dma_wnext}, 32'd0);
        checkOutput("reset_rdata", dma_rdata, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_ctl", {29'd0, mem_read, mem_write}, 32'd0);

        // CPU-only read and write pass straight through.
        use_fixed   = 1'b1;
        fixed_rdata = 32'hDEAD_BEEF;
        applyStimulus(1, 2'd0, 32'h10, 0);
        checkOutput("cpu_rd_addr", mem_addr, 32'h10);
        checkOutput("cpu_rd_read", 32'(mem_read), 32'd1);
        checkOutput("cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        checkOutput("cpu_rd_dma_idle", {28'd0, dma_busy, dma_valid, dma_done, dma_wnext}, 32'd0);
        cpu_wdata = 32'hCAFE_F00D;
        applyStimulus(0, 2'd3, 32'h44, 0);
        checkOutput("cpu_wr_code", 32'(mem_write), 32'd3);
        checkOutput("cpu_wr_data", mem_wdata, 32'hCAFE_F00D);
        applyStimulus(0, 2'd0, 32'h0, 0);
        checkOutput("idle_mem_wdata", mem_wdata, 32'd0);

        // Write burst of four words, with a stray request while busy.
        dma_write = 1'b1;
        dma_addr  = 32'h100;
        dma_len   = 4'd3;
        applyStimulus(0, 2'd0, 32'h0, 1);
        t0 = cyc;
        for (int k = 0; k < 4; k++) pushWrite(t0 + 1 + k, 32'h100 + 32'(2 * k));
        done_q.push_back(t0 + 5);
        applyStimulus(0, 2'd0, 32'h0, 0);
        checkOutput("wr_busy", 32'(dma_busy), 32'd1);
        dma_addr = 32'h900;
        applyStimulus(0, 2'd0, 32'h0, 1);
        for (int k = 0; k < 4; k++) applyStimulus(0, 2'd0, 32'h0, 0);
        checkOutput("wr_idle_after", 32'(dma_busy), 32'd0);

        // Single-word read with a fixed memory value.
        fixed_rdata = 32'h1234_5678;
        dma_write   = 1'b0;
        dma_addr    = 32'h300;
        dma_len     = 4'd0;
        applyStimulus(0, 2'd0, 32'h0, 1);
        t0 = cyc;
        pushRead(t0 + 3, 32'h1234_5678);
        done_q.push_back(t0 + 3);
        applyStimulus(0, 2'd0, 32'h0, 0);
        checkOutput("rd_issue_addr", mem_addr, 32'h300);
        checkOutput("rd_issue_read", 32'(mem_read), 32'd1);
        applyStimulus(0, 2'd0, 32'h0, 0);
        checkOutput("rd_wait_hold", mem_addr, 32'h300);
        applyStimulus(0, 2'd0, 32'h0, 0);
        applyStimulus(0, 2'd0, 32'h0, 0);
        checkOutput("rd_idle_rdata", dma_rdata, 32'd0);

        // Read interrupted by the CPU in WAIT is retried.
        use_fixed = 1'b0;
        dma_addr  = 32'h200;
        applyStimulus(0, 2'd0, 32'h0, 1);
        t0 = cyc;
        pushRead(t0 + 5, 32'h5A5A_0200);
        done_q.push_back(t0 + 5);
        applyStimulus(0, 2'd0, 32'h0, 0);
        applyStimulus(1, 2'd0, 32'h40, 0);
        checkOutput("retry_cpu_addr", mem_addr, 32'h40);
        applyStimulus(0, 2'd0, 32'h0, 0);
        checkOutput("retry_reissue_addr", mem_addr, 32'h200);
        checkOutput("retry_reissue_read", 32'(mem_read), 32'd1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 2'd0, 32'h0, 0);
`ifdef MEM_ARB_STATS_EN
        checkOutput("conflict_after_retry", 32'(conflict_cnt), 32'd1);
`endif

        // Five CPU cycles stall a write burst in ISSUE; second word wraps the address.
        dma_write = 1'b1;
        dma_addr  = 32'hFFFF_FFFE;
        dma_len   = 4'd1;
        applyStimulus(0, 2'd0, 32'h0, 1);
        t0 = cyc;
        pushWrite(t0 + 6, 32'hFFFF_FFFE);
        pushWrite(t0 + 7, 32'h0000_0000);
        done_q.push_back(t0 + 8);
        for (int k = 0; k < 5; k++) begin
            cpu_wdata = 32'h1111_0000 + 32'(k);
            applyStimulus(0, 2'd1, 32'h80, 0);
            checkOutput("stall_wnext", 32'(dma_wnext), 32'd0);
            checkOutput("stall_mem_write", 32'(mem_write), 32'd1);
        end
        for (int k = 0; k < 4; k++) applyStimulus(0, 2'd0, 32'h0, 0);
`ifdef MEM_ARB_STATS_EN
        checkOutput("conflict_after_stall", 32'(conflict_cnt), 32'd6);
`endif

        // Reset during WAIT of a read burst aborts it silently.
        dma_write = 1'b0;
        dma_addr  = 32'h400;
        dma_len   = 4'd2;
        applyStimulus(0, 2'd0, 32'h0, 1);
        applyStimulus(0, 2'd0, 32'h0, 0);
        applyStimulus(0, 2'd0, 32'h0, 0);
        rst = 1'b1;
        applyStimulus(0, 2'd0, 32'h0, 0);
        rst = 1'b0;
        checkOutput("midrst_dma_flags", {28'd0, dma_busy, dma_valid, dma_done, dma_wnext}, 32'd0);
        checkOutput("midrst_rdata", dma_rdata, 32'd0);
        checkOutput("midrst_mem", {29'd0, mem_read, mem_write}, 32'd0);
`ifdef MEM_ARB_STATS_EN
        checkOutput("midrst_conflict", 32'(conflict_cnt), 32'd0);
`endif
        for (int k = 0; k < 3; k++) applyStimulus(0, 2'd0, 32'h0, 0);

        // Two-word read after the aborted burst.
        dma_addr = 32'h500;
        dma_len  = 4'd1;
        applyStimulus(0, 2'd0, 32'h0, 1);
        t0 = cyc;
        pushRead(t0 + 3, 32'h5A5A_0500);
        pushRead(t0 + 5, 32'h5A5A_0502);
        done_q.push_back(t0 + 5);
        for (int k = 0; k < 7; k++) applyStimulus(0, 2'd0, 32'h0, 0);

        checkOutput("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        checkOutput("done_queue_drained", 32'(done_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between the CPU and a DMA master. The CPU always has absolute priority and sees zero added latency, because its fixed stage sequence cannot stall. DMA traffic runs as word bursts in idle bus cycles. A DMA read word interrupted by the CPU is retried from its address phase. The block sits between the CPU memory signals (`Memread`/`Memwrite`/`Addr`/`BUS`) and the memory.

## Interface
- `ADDR_STEP`, default 2: address increment between burst words.
- `RD_LAT`, default 1: memory read latency in cycles (≥1).
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_memread` in 1: CPU read request.
- `cpu_memwrite` in 2: CPU write code (0 none, 1 word, 3 byte).
- `cpu_addr` in 32: CPU address.
- `cpu_wdata` in 32: CPU write data.
- `cpu_rdata` out 32: `mem_rdata` passed through combinationally.
- `dma_req` in 1: start burst; sampled only in IDLE.
- `dma_write` in 1: 1 = write burst, 0 = read burst.
- `dma_addr` in 32: burst start address.
- `dma_len` in 4: burst length minus one (1–16 words).
- `dma_wdata` in 32: write word, consumed when `dma_wnext`=1.
- `dma_wnext` out 1: current write word issued this cycle.
- `dma_rdata` out 32: registered read word.
- `dma_valid` out 1: one-cycle strobe, `dma_rdata` valid.
- `dma_done` out 1: one-cycle strobe, burst complete.
- `dma_busy` out 1: high in every state other than IDLE.
- `mem_read` out 1: memory read.
- `mem_write` out 2: memory write code (0 none, 1 word, 2 DMA word, 3 byte).
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data.

## Operation
- `cpu_act` = `cpu_memread` | (`cpu_memwrite`≠0).
- When `cpu_act`=1, the `mem_*` outputs equal the CPU signals combinationally. The CPU wins unconditionally.
- States:
  - IDLE: if `dma_req`, latch addr, len, and write flag, then go to ISSUE. All DMA outputs are 0.
  - ISSUE, with `cpu_act`: stay in ISSUE (stall).
  - ISSUE, read, no `cpu_act`:
    - drive `mem_read`=1 with the DMA address;
    - load the wait counter with `RD_LAT`;
    - go to WAIT.
  - ISSUE, write, no `cpu_act`:
    - drive `mem_write`=2, DMA address, and `dma_wdata`;
    - assert `dma_wnext`;
    - the word is complete.
  - WAIT, with `cpu_act`: abort the word and return to ISSUE at the same address (retry).
  - WAIT, no `cpu_act`: hold `mem_read`/`mem_addr` and decrement the counter. At the counter's last cycle, capture `mem_rdata` into `dma_rdata`; the word is complete. `dma_valid`=1 in the next cycle.
  - Word complete, remaining>0: addr += `ADDR_STEP` (mod 2^32), remaining−1, go to ISSUE.
  - Word complete, remaining=0: go to DONE.
  - DONE: `dma_done`=1 for one cycle, then IDLE.
- When neither CPU nor DMA drives the port: `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- `dma_req` while busy is ignored. A new burst is accepted no earlier than the first IDLE cycle after DONE.
- Address wrap past 0xFFFFFFFF wraps silently.

## Timing
- Reset: state IDLE, counters 0, `dma_rdata`=0. `dma_valid`, `dma_done`, `dma_busy`, and `dma_wnext` are all 0.
- Reset mid-burst aborts the burst with no `dma_done`.
- CPU path: 0-cycle latency, purely combinational.
- Write burst with no conflicts: accepted at edge 0; words issued in cycles 1..N; `dma_done` in cycle N+1.
- Read word with no conflicts: 1+`RD_LAT` cycles. `dma_valid` coincides with the next ISSUE or DONE cycle.
- `cpu_act` in the same cycle as DMA ISSUE: the CPU is issued and the DMA stalls; no `dma_wnext`.

## Configuration
- `MEM_ARB_STATS_EN` defined: adds output `conflict_cnt` [15:0].
  - Counts cycles in which the DMA is in ISSUE or WAIT and `cpu_act`=1.
  - Saturates at 0xFFFF; cleared by `rst`.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset mid read-burst (state WAIT): all outputs 0 the cycle after reset, no `dma_done`, next `dma_req` accepted normally.
- CPU only, `cpu_memread`=1, addr 0x10, `mem_rdata`=0xDEADBEEF: `mem_addr`=0x10 and `cpu_rdata`=0xDEADBEEF in the same cycle; DMA outputs 0.
- DMA write: `dma_addr`=0x100, `dma_len`=3, no CPU:
  - `mem_write`=2 at 0x100, 0x102, 0x104, 0x106 in cycles 1–4;
  - `dma_wnext` high in cycles 1–4;
  - `dma_done` in cycle 5.
- DMA read: `dma_len`=0, `RD_LAT`=1, memory returns 0x12345678: `dma_valid`=1 with `dma_rdata`=0x12345678 in cycle 3, `dma_done` in cycle 3.
- Retry case:
  - Stimulus: DMA read at 0x200; `cpu_memread` asserted during WAIT.
  - Required: CPU address on `mem_addr` that cycle; DMA re-issues 0x200 in the next free cycle; the final data is correct.
  - With `MEM_ARB_STATS_EN`: `conflict_cnt`=1.
- CPU active for 5 consecutive cycles while DMA is in ISSUE: zero `dma_wnext`/`mem_write`=2 during those cycles. With stats enabled, `conflict_cnt`=5.
